// File: rtl/tile_scan_gen.sv
// tile_scan_gen: converts a pixel-space primitive bounding box to tile
// coordinates, clips it to the screen tile grid, and streams every covered
// tile (one per cycle) to the tile evaluator with first/last tagging.
//
// Optional feature macro: TILE_SERPENTINE_EN (boustrophedon row order).
// Without it the scan is plain raster order.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   bb_valid/bb_ready             box handshake (accepted only in IDLE)
//   bb_min_x/y, bb_max_x/y        inclusive pixel box
//   bb_id                         primitive tag
//   t_valid/t_ready               tile stream handshake
//   t_x, t_y, t_id                tile coordinate and owning tag
//   t_first, t_last               first/last tile of the primitive
//   tile_cnt                      tiles handshaken for current/last primitive
//   done                          one-cycle pulse when a primitive finishes
//   busy                          high in SETUP or EMIT
module tile_scan_gen #(
  parameter int COORD_W    = 10,
  parameter int TILE_SHIFT = 3,
  parameter int SCREEN_TX  = 80,
  parameter int SCREEN_TY  = 60,
  parameter int ID_W       = 8,
  parameter int CNT_W      = 14,
  localparam int TILE_W    = COORD_W - TILE_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bb_valid,
  output logic              bb_ready,
  input  logic [COORD_W-1:0] bb_min_x,
  input  logic [COORD_W-1:0] bb_min_y,
  input  logic [COORD_W-1:0] bb_max_x,
  input  logic [COORD_W-1:0] bb_max_y,
  input  logic [ID_W-1:0]   bb_id,
  output logic              t_valid,
  input  logic              t_ready,
  output logic [TILE_W-1:0] t_x,
  output logic [TILE_W-1:0] t_y,
  output logic [ID_W-1:0]   t_id,
  output logic              t_first,
  output logic              t_last,
  output logic [CNT_W-1:0]  tile_cnt,
  output logic              done,
  output logic              busy
);

  localparam logic [TILE_W-1:0] MAX_TX = TILE_W'(SCREEN_TX - 1);
  localparam logic [TILE_W-1:0] MAX_TY = TILE_W'(SCREEN_TY - 1);

  typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

  state_t              state_q, state_d;
  logic [COORD_W-1:0]  min_x_q, min_x_d, min_y_q, min_y_d;
  logic [COORD_W-1:0]  max_x_q, max_x_d, max_y_q, max_y_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [TILE_W-1:0]   tx0_q, tx0_d, tx1_q, tx1_d, ty1_q, ty1_d;
  logic [TILE_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic                first_q, first_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
`ifdef TILE_SERPENTINE_EN
  logic                dir_q, dir_d;  // 1: current row scans right-to-left
`endif

  // Setup-time tile conversion of the registered box
  logic [TILE_W-1:0] bx0, by0, bx1_raw, by1_raw, bx1, by1;
  logic              empty, row_end, at_last;

  always_comb begin
    bx0     = TILE_W'(min_x_q >> TILE_SHIFT);
    by0     = TILE_W'(min_y_q >> TILE_SHIFT);
    bx1_raw = TILE_W'(max_x_q >> TILE_SHIFT);
    by1_raw = TILE_W'(max_y_q >> TILE_SHIFT);
    bx1     = (bx1_raw > MAX_TX) ? MAX_TX : bx1_raw;
    by1     = (by1_raw > MAX_TY) ? MAX_TY : by1_raw;
    // An off-screen start corner means nothing survives the clip.
    empty   = (min_x_q > max_x_q) || (min_y_q > max_y_q) ||
              (bx0 > MAX_TX) || (by0 > MAX_TY);
`ifdef TILE_SERPENTINE_EN
    row_end = dir_q ? (cx_q == tx0_q) : (cx_q == tx1_q);
`else
    row_end = (cx_q == tx1_q);
`endif
    at_last = row_end && (cy_q == ty1_q);
  end

  always_comb begin
    state_d = state_q;
    min_x_d = min_x_q;
    min_y_d = min_y_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    id_d    = id_q;
    tx0_d   = tx0_q;
    tx1_d   = tx1_q;
    ty1_d   = ty1_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef TILE_SERPENTINE_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (bb_valid) begin
          min_x_d = bb_min_x;
          min_y_d = bb_min_y;
          max_x_d = bb_max_x;
          max_y_d = bb_max_y;
          id_d    = bb_id;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tx0_d   = bx0;
          tx1_d   = bx1;
          ty1_d   = by1;
          cx_d    = bx0;
          cy_d    = by0;
          first_d = 1'b1;
`ifdef TILE_SERPENTINE_EN
          dir_d   = 1'b0;
`endif
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (t_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          first_d = 1'b0;
          if (at_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (row_end) begin
            cy_d = cy_q + TILE_W'(1);
`ifdef TILE_SERPENTINE_EN
            // New row starts at the column we ended on, scanning back.
            dir_d = ~dir_q;
`else
            cx_d = tx0_q;
`endif
          end else begin
`ifdef TILE_SERPENTINE_EN
            cx_d = dir_q ? (cx_q - TILE_W'(1)) : (cx_q + TILE_W'(1));
`else
            cx_d = cx_q + TILE_W'(1);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      min_x_q <= '0;
      min_y_q <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      id_q    <= '0;
      tx0_q   <= '0;
      tx1_q   <= '0;
      ty1_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef TILE_SERPENTINE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      min_x_q <= min_x_d;
      min_y_q <= min_y_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      id_q    <= id_d;
      tx0_q   <= tx0_d;
      tx1_q   <= tx1_d;
      ty1_q   <= ty1_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef TILE_SERPENTINE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign bb_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign t_valid  = (state_q == EMIT);
  assign t_x      = cx_q;
  assign t_y      = cy_q;
  assign t_id     = id_q;
  assign t_first  = t_valid & first_q;
  assign t_last   = t_valid & at_last;
  assign tile_cnt = cnt_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tile_scan_gen.sv
module tb_tile_scan_gen;
  localparam int COORD_W = 10;
  localparam int TW      = 7;
  localparam int ID_W    = 8;
  localparam int CNT_W   = 14;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               bb_valid = 1'b0;
  logic               bb_ready;
  logic [COORD_W-1:0] bb_min_x = '0, bb_min_y = '0, bb_max_x = '0, bb_max_y = '0;
  logic [ID_W-1:0]    bb_id = '0;
  logic               t_valid;
  logic               t_ready = 1'b1;
  logic [TW-1:0]      t_x, t_y;
  logic [ID_W-1:0]    t_id;
  logic               t_first, t_last;
  logic [CNT_W-1:0]   tile_cnt;
  logic               done, busy;

  tile_scan_gen dut (
    .clk(clk), .rst(rst),
    .bb_valid(bb_valid), .bb_ready(bb_ready),
    .bb_min_x(bb_min_x), .bb_min_y(bb_min_y),
    .bb_max_x(bb_max_x), .bb_max_y(bb_max_y),
    .bb_id(bb_id),
    .t_valid(t_valid), .t_ready(t_ready),
    .t_x(t_x), .t_y(t_y), .t_id(t_id),
    .t_first(t_first), .t_last(t_last),
    .tile_cnt(tile_cnt), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Capture of one primitive's tile stream
  int got_x[64], got_y[64], got_f[64], got_l[64];
  int got_n, done_lat, hold_bad, hold_cmp, id_bad, setup_bad;

  // Offer one box, collect its tiles. When tile index stall_at is first
  // presented, t_ready is held low for stall_len cycles.
  task automatic run_box(input int mnx, input int mny, input int mxx, input int mxy,
                         input int id, input int stall_at, input int stall_len);
    int cyc, stall_left, hx, hy, hf, hl, hid;
    bit stalled;
    got_n = 0; done_lat = -1; hold_bad = 0; hold_cmp = 0; id_bad = 0; setup_bad = 0;
    stall_left = 0; stalled = 0; hx = 0; hy = 0; hf = 0; hl = 0; hid = 0;
    @(negedge clk);
    bb_min_x = COORD_W'(mnx); bb_min_y = COORD_W'(mny);
    bb_max_x = COORD_W'(mxx); bb_max_y = COORD_W'(mxy);
    bb_id = ID_W'(id); bb_valid = 1'b1; t_ready = 1'b1;
    @(posedge clk);
    #1 bb_valid = 1'b0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && (t_valid || !busy || bb_ready)) setup_bad++;
      if (done) begin done_lat = cyc; break; end
      if (t_valid) begin
        if (stall_left > 0) begin
          hold_cmp++;
          if (int'(t_x) != hx || int'(t_y) != hy || int'(t_first) != hf ||
              int'(t_last) != hl || int'(t_id) != hid) hold_bad++;
          stall_left--;
          t_ready = (stall_left == 0);
        end else if (got_n == stall_at && !stalled && stall_len > 0) begin
          stalled = 1; stall_left = stall_len; t_ready = 1'b0;
          hx = int'(t_x); hy = int'(t_y); hf = int'(t_first); hl = int'(t_last); hid = int'(t_id);
        end else begin
          t_ready = 1'b1;
        end
        if (t_ready && got_n < 64) begin
          got_x[got_n] = int'(t_x); got_y[got_n] = int'(t_y);
          got_f[got_n] = int'(t_first); got_l[got_n] = int'(t_last);
          if (int'(t_id) != id) id_bad++;
          got_n++;
        end
      end
    end
    t_ready = 1'b1;
  endtask

  typedef struct {
    int mnx, mny, mxx, mxy, id;
    int n, fx, fy, lx, ly;
  } vec_t;

  vec_t vt[9];
  int   sf, sl;
  int   ex_x[4], ex_y[4];
  int   bad;

  initial begin
    // {box, id, tile count, first tile, last tile}
`ifdef TILE_SERPENTINE_EN
    vt[0] = '{0, 0, 15, 15, 1, 4, 0, 0, 0, 1};
    vt[1] = '{600, 470, 1023, 1023, 2, 10, 75, 58, 75, 59};
    ex_x = '{0, 1, 1, 0}; ex_y = '{0, 0, 1, 1};
`else
    vt[0] = '{0, 0, 15, 15, 1, 4, 0, 0, 1, 1};
    vt[1] = '{600, 470, 1023, 1023, 2, 10, 75, 58, 79, 59};
    ex_x = '{0, 1, 0, 1}; ex_y = '{0, 0, 1, 1};
`endif
    vt[2] = '{20, 0, 10, 0, 3, 0, 0, 0, 0, 0};     // min_x > max_x
    vt[3] = '{700, 0, 710, 5, 4, 0, 0, 0, 0, 0};   // starts right of screen
    vt[4] = '{9, 9, 9, 9, 5, 1, 1, 1, 1, 1};       // single tile
    vt[5] = '{0, 0, 23, 7, 6, 3, 0, 0, 2, 0};
    vt[6] = '{8, 16, 31, 23, 7, 3, 1, 2, 3, 2};
    vt[7] = '{0, 480, 5, 490, 8, 0, 0, 0, 0, 0};   // starts below screen
    vt[8] = '{0, 10, 5, 2, 9, 0, 0, 0, 0, 0};      // min_y > max_y

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_t_valid", int'(t_valid), 0);
    chk("rst_flags", int'({t_first, t_last, done, busy}), 0);
    chk("rst_txy", int'(t_x) * 256 + int'(t_y), 0);
    chk("rst_cnt", int'(tile_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bb_ready", int'(bb_ready), 1);

    // Table of boxes, t_ready held high
    foreach (vt[i]) begin
      run_box(vt[i].mnx, vt[i].mny, vt[i].mxx, vt[i].mxy, vt[i].id, -1, 0);
      chk($sformatf("v%0d_ntiles", i), got_n, vt[i].n);
      chk($sformatf("v%0d_done_lat", i), done_lat, vt[i].n + 2);
      chk($sformatf("v%0d_tile_cnt", i), int'(tile_cnt), vt[i].n);
      chk($sformatf("v%0d_setup", i), setup_bad, 0);
      chk($sformatf("v%0d_id", i), id_bad, 0);
      chk($sformatf("v%0d_bb_ready", i), int'(bb_ready), 1);
      if (vt[i].n > 0) begin
        sf = 0; sl = 0;
        for (int k = 0; k < got_n; k++) begin sf += got_f[k]; sl += got_l[k]; end
        chk($sformatf("v%0d_first_xy", i), got_x[0] * 256 + got_y[0], vt[i].fx * 256 + vt[i].fy);
        chk($sformatf("v%0d_last_xy", i), got_x[got_n-1] * 256 + got_y[got_n-1],
            vt[i].lx * 256 + vt[i].ly);
        chk($sformatf("v%0d_first_flag", i), got_f[0] * 16 + sf, 17);
        chk($sformatf("v%0d_last_flag", i), got_l[got_n-1] * 16 + sl, 17);
      end
    end

    // Full scan order of a 2x2 box
    run_box(0, 0, 15, 15, 11, -1, 0);
    chk("order_n", got_n, 4);
    if (got_n == 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("order_tile%0d", k), got_x[k] * 256 + got_y[k], ex_x[k] * 256 + ex_y[k]);

    // Backpressure: stall 3 cycles while the second tile is presented
    run_box(0, 0, 23, 7, 12, 1, 3);
    chk("bp_hold_cmp", hold_cmp, 3);
    chk("bp_hold_stable", hold_bad, 0);
    chk("bp_ntiles", got_n, 3);
    bad = 0;
    for (int k = 0; k < got_n && k < 3; k++) if (got_x[k] != k || got_y[k] != 0) bad++;
    chk("bp_sequence", bad, 0);
    chk("bp_tile_cnt", int'(tile_cnt), 3);
    chk("bp_done_lat", done_lat, 8);

    // Reset during tile 3 of 4
    @(negedge clk);
    bb_min_x = 0; bb_min_y = 0; bb_max_x = 15; bb_max_y = 15; bb_id = 8'd33;
    bb_valid = 1'b1; t_ready = 1'b1;
    @(posedge clk);
    #1 bb_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid_valid_before", int'(t_valid) * 16 + int'(tile_cnt), 16 + 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_t_valid", int'(t_valid), 0);
    chk("mid_rst_flags", int'({t_first, t_last, done, busy}), 0);
    chk("mid_rst_txy_id", int'(t_x) * 65536 + int'(t_y) * 256 + int'(t_id), 0);
    chk("mid_rst_cnt", int'(tile_cnt), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("mid_bb_ready", int'(bb_ready), 1);
      if (done || t_valid || busy) bad++;
    end
    chk("mid_no_done", bad, 0);

    // Recovers cleanly after the discarded primitive
    run_box(9, 9, 9, 9, 44, -1, 0);
    chk("post_rst_single", got_n * 256 + got_x[0] * 16 + got_y[0], 256 + 17);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
